tube_host_master: RTL and testbench

TUBE_HOST_MASTER -- requirements
Module: tube_host_master

---
 rtl/tube_host_master.sv | 201 ++++++++++++++++++++
 tb/tb_tube_host_master.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tube_host_master.sv
// Host-side Tube bus master: turns single-byte commands into status-polled
// register accesses on a divided, free-running phi2 bus.
module tube_host_master #(
    parameter int unsigned CLK_DIV    = 2,
    parameter int unsigned POLL_LIMIT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [1:0] cmd_reg,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_err,
    output logic       h_phi2,
    output logic [2:0] h_addr,
    output logic       h_cs_b,
    output logic       h_rdnw,
    output logic [7:0] h_data_out,
    output logic       h_data_oe,
    input  logic [7:0] h_data_in,
    input  logic       h_irq_b,
    output logic       host_irq
);

    typedef enum logic [1:0] {StIdle, StPoll, StData, StResp} state_e;

    localparam logic [7:0]  DivLast   = 8'(CLK_DIV - 1);
    localparam logic [16:0] PollLimit = 17'(POLL_LIMIT);

    state_e      state_q, state_d;
    logic [7:0]  div_cnt_q;
    logic        phi2_q;
    logic        alive_q;
    logic [1:0]  op_q, op_d;
    logic [1:0]  reg_q, reg_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [15:0] poll_cnt_q, poll_cnt_d;
    logic        cs_b_q, cs_b_d;
    logic        rdnw_q, rdnw_d;
    logic [2:0]  addr_q, addr_d;
    logic        wr_q, wr_d;
    logic [7:0]  rsp_data_q, rsp_data_d;
    logic        rsp_err_q, rsp_err_d;
    logic        irq_s1_q, irq_s2_q;

    logic        fall;
    logic        data_wr;
    logic [2:0]  data_addr;
    logic        poll_ok;
    logic [16:0] cnt_inc;
    logic [15:0] cnt_sat;

    // The edge that ends phi2-high both completes one bus cycle and starts the next.
    assign fall = phi2_q && (div_cnt_q == DivLast);

    assign data_wr = op_q[1] ^ op_q[0];
    assign poll_ok = op_q[0] ? h_data_in[6] : h_data_in[7];
    assign cnt_inc = {1'b0, poll_cnt_q} + 17'd1;
    assign cnt_sat = (&poll_cnt_q) ? poll_cnt_q : cnt_inc[15:0];

    always_comb begin
        data_addr = 3'd0;
        unique case (op_q)
            2'b00, 2'b01: data_addr = {reg_q, 1'b1};
            2'b10:        data_addr = 3'd0;
            2'b11:        data_addr = {reg_q, 1'b0};
        endcase
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        reg_d      = reg_q;
        wdata_d    = wdata_q;
        poll_cnt_d = poll_cnt_q;
        cs_b_d     = cs_b_q;
        rdnw_d     = rdnw_q;
        addr_d     = addr_q;
        wr_d       = wr_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid && cmd_ready) begin
                    op_d       = cmd_op;
                    reg_d      = cmd_reg;
                    wdata_d    = cmd_wdata;
                    poll_cnt_d = '0;
                    state_d    = cmd_op[1] ? StData : StPoll;
                end
            end
            StPoll: begin
                if (fall) begin
                    if (!cs_b_q && poll_ok) begin
                        state_d = StData;
                        cs_b_d  = 1'b0;
                        rdnw_d  = ~data_wr;
                        wr_d    = data_wr;
                        addr_d  = data_addr;
                    end else if (!cs_b_q && (cnt_inc >= PollLimit)) begin
                        poll_cnt_d = cnt_sat;
                        rsp_err_d  = 1'b1;
                        rsp_data_d = h_data_in;
                        state_d    = StResp;
                        cs_b_d     = 1'b1;
                        rdnw_d     = 1'b1;
                        wr_d       = 1'b0;
                    end else begin
                        // cs_b_q high means no poll has completed yet, so nothing to count
                        if (!cs_b_q) poll_cnt_d = cnt_sat;
                        cs_b_d = 1'b0;
                        rdnw_d = 1'b1;
                        wr_d   = 1'b0;
                        addr_d = {reg_q, 1'b0};
                    end
                end
            end
            StData: begin
                if (fall) begin
                    if (!cs_b_q) begin
                        rsp_err_d  = 1'b0;
                        rsp_data_d = data_wr ? 8'h00 : h_data_in;
                        state_d    = StResp;
                        cs_b_d     = 1'b1;
                        rdnw_d     = 1'b1;
                        wr_d       = 1'b0;
                    end else begin
                        cs_b_d = 1'b0;
                        rdnw_d = ~data_wr;
                        wr_d   = data_wr;
                        addr_d = data_addr;
                    end
                end
            end
            StResp: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q <= '0;
            phi2_q    <= 1'b0;
        end else if (div_cnt_q == DivLast) begin
            div_cnt_q <= '0;
            phi2_q    <= ~phi2_q;
        end else begin
            div_cnt_q <= div_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            alive_q    <= 1'b0;
            op_q       <= '0;
            reg_q      <= '0;
            wdata_q    <= '0;
            poll_cnt_q <= '0;
            cs_b_q     <= 1'b1;
            rdnw_q     <= 1'b1;
            addr_q     <= '0;
            wr_q       <= 1'b0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            irq_s1_q   <= 1'b0;
            irq_s2_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            alive_q    <= 1'b1;
            op_q       <= op_d;
            reg_q      <= reg_d;
            wdata_q    <= wdata_d;
            poll_cnt_q <= poll_cnt_d;
            cs_b_q     <= cs_b_d;
            rdnw_q     <= rdnw_d;
            addr_q     <= addr_d;
            wr_q       <= wr_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            irq_s1_q   <= ~h_irq_b;
            irq_s2_q   <= irq_s1_q;
        end
    end

    // alive_q keeps cmd_ready low while reset is held.
    assign cmd_ready  = alive_q && (state_q == StIdle);
    assign rsp_valid  = (state_q == StResp);
    assign rsp_data   = rsp_data_q;
    assign rsp_err    = rsp_err_q;
    assign h_phi2     = phi2_q;
    assign h_addr     = addr_q;
    assign h_cs_b     = cs_b_q;
    assign h_rdnw     = rdnw_q;
    assign h_data_oe  = wr_q && phi2_q;
    assign h_data_out = h_data_oe ? wdata_q : 8'h00;
    assign host_irq   = irq_s2_q;

endmodule

// File: tb/tb_tube_host_master.sv
// Directed bench for tube_host_master: three instances (CLK_DIV 2, 1, 3) share
// one Tube register model; sel chooses which one is driven and observed.
module tb_tube_host_master;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         sel = 0;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = '0;
    logic [1:0] cmd_reg = '0;
    logic [7:0] cmd_wdata = '0;
    logic [7:0] h_data_in = '0;
    logic       h_irq_b = 1'b1;

    logic       v_ready[3], v_rsp_valid[3], v_rsp_err[3], v_phi2[3];
    logic       v_cs_b[3], v_rdnw[3], v_oe[3], v_irq[3];
    logic [7:0] v_rsp_data[3], v_dout[3];
    logic [2:0] v_addr[3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        tube_host_master #(
            .CLK_DIV   (g == 0 ? 2 : (g == 1 ? 1 : 3)),
            .POLL_LIMIT(4)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .cmd_valid (cmd_valid && (sel == g)),
            .cmd_ready (v_ready[g]),
            .cmd_op    (cmd_op),
            .cmd_reg   (cmd_reg),
            .cmd_wdata (cmd_wdata),
            .rsp_valid (v_rsp_valid[g]),
            .rsp_data  (v_rsp_data[g]),
            .rsp_err   (v_rsp_err[g]),
            .h_phi2    (v_phi2[g]),
            .h_addr    (v_addr[g]),
            .h_cs_b    (v_cs_b[g]),
            .h_rdnw    (v_rdnw[g]),
            .h_data_out(v_dout[g]),
            .h_data_oe (v_oe[g]),
            .h_data_in (h_data_in),
            .h_irq_b   (h_irq_b),
            .host_irq  (v_irq[g])
        );
    end

    logic       ready_m, rsp_valid_m, rsp_err_m, phi2_m, cs_b_m, rdnw_m, oe_m, irq_m;
    logic [7:0] rsp_data_m, dout_m;
    logic [2:0] addr_m;

    assign ready_m     = v_ready[sel];
    assign rsp_valid_m = v_rsp_valid[sel];
    assign rsp_err_m   = v_rsp_err[sel];
    assign rsp_data_m  = v_rsp_data[sel];
    assign phi2_m      = v_phi2[sel];
    assign cs_b_m      = v_cs_b[sel];
    assign rdnw_m      = v_rdnw[sel];
    assign oe_m        = v_oe[sel];
    assign dout_m      = v_dout[sel];
    assign addr_m      = v_addr[sel];
    assign irq_m       = v_irq[sel];

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s (div %0d): observed 0x%0h, expected 0x%0h",
                      tag, div_of(sel), obs, exp);
    endtask

    function automatic int div_of(input int s);
        return (s == 1) ? 1 : ((s == 2) ? 3 : 2);
    endfunction

    // Tube register model plus bus-protocol watchdogs.
    logic [7:0] stat_seq[4];
    int         stat_n = 1;
    int         stat_idx = 0;
    logic [7:0] fifo_byte = 8'h00;
    int         nlog = 0;
    logic [2:0] log_addr[16];
    logic       log_rd[16];
    logic [7:0] log_data[16];
    int         bad_bus = 0;
    int         bad_oe = 0;
    int         rsp_cnt = 0;
    logic       prev_phi2 = 1'b0;
    logic [4:0] prev_bus = 5'b11000;
    logic [7:0] rd_byte;

    always @(negedge clk) begin
        if (!rst) begin
            if ({cs_b_m, rdnw_m, addr_m} != prev_bus && !(prev_phi2 && !phi2_m)) bad_bus++;
            if (cs_b_m && (!rdnw_m || oe_m)) bad_bus++;
            if (oe_m && !phi2_m) bad_oe++;
            if (!cs_b_m && !rdnw_m && phi2_m && !oe_m) bad_oe++;
            if (rsp_valid_m) rsp_cnt++;
            if (phi2_m && !prev_phi2 && !cs_b_m) begin
                if (addr_m[0]) rd_byte = fifo_byte;
                else rd_byte = stat_seq[(stat_idx < stat_n) ? stat_idx : stat_n - 1];
                if (rdnw_m) begin
                    if (!addr_m[0]) stat_idx++;
                    h_data_in = rd_byte;
                end
                if (nlog < 16) begin
                    log_addr[nlog] = addr_m;
                    log_rd[nlog]   = rdnw_m;
                    log_data[nlog] = rdnw_m ? rd_byte : (oe_m ? dout_m : 8'h00);
                end
                nlog++;
            end
        end
        prev_phi2 = phi2_m;
        prev_bus  = {cs_b_m, rdnw_m, addr_m};
    end

    task automatic start_test(input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] s2,
                              input logic [7:0] s3, input int n, input logic [7:0] fb);
        stat_seq[0] = s0;
        stat_seq[1] = s1;
        stat_seq[2] = s2;
        stat_seq[3] = s3;
        stat_n      = n;
        stat_idx    = 0;
        fifo_byte   = fb;
        nlog        = 0;
        bad_bus     = 0;
        bad_oe      = 0;
    endtask

    task automatic send(input logic [1:0] op, input logic [1:0] rg, input logic [7:0] wd);
        int i;
        i = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_reg   = rg;
        cmd_wdata = wd;
        while (!ready_m && i < 200) begin
            @(negedge clk);
            i++;
        end
        check("cmd_ready", ready_m, 1'b1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic expect_rsp(input string tag, input logic [7:0] d, input logic e);
        int i;
        i = 0;
        while (!rsp_valid_m && i < 2000) begin
            @(negedge clk);
            i++;
        end
        check({tag, "_rsp_seen"}, rsp_valid_m, 1'b1);
        check({tag, "_rsp"}, {rsp_err_m, rsp_data_m}, {e, d});
        @(negedge clk);
        check({tag, "_rsp_pulse"}, rsp_valid_m, 1'b0);
        check({tag, "_rsp_hold"}, {rsp_err_m, rsp_data_m}, {e, d});
    endtask

    task automatic expect_cyc(input string tag, input int i, input logic [2:0] a, input logic r,
                              input logic [7:0] d);
        check(tag, {log_addr[i], log_rd[i], log_data[i]}, {a, r, d});
    endtask

    task automatic expect_clean(input string tag, input int n);
        check({tag, "_cycles"}, nlog, n);
        check({tag, "_bus_timing"}, bad_bus, 0);
        check({tag, "_oe_timing"}, bad_oe, 0);
    endtask

    initial begin
        int n;
        int rc;
        for (int s = 0; s < 3; s++) begin
            rst = 1'b1;
            sel = s;
            repeat (3) @(negedge clk);
            check("reset_outputs",
                  {phi2_m, cs_b_m, rdnw_m, addr_m, oe_m, dout_m, ready_m, rsp_valid_m,
                   rsp_err_m, rsp_data_m, irq_m},
                  {1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0});
            rst = 1'b0;
            @(posedge clk);
            #1 check("ready_after_reset", ready_m, 1'b1);
            n = 1;
            while (!phi2_m && n < 20) begin
                @(posedge clk);
                #1 n++;
            end
            check("first_phi2_rise", n, div_of(s));
            n = 0;
            while (phi2_m && n < 50) begin
                @(posedge clk);
                #1 n++;
            end
            while (!phi2_m && n < 50) begin
                @(posedge clk);
                #1 n++;
            end
            check("phi2_period", n, 2 * div_of(s));

            // Control write: no poll, write addr 0
            start_test(8'h00, 8'h00, 8'h00, 8'h00, 1, 8'h00);
            send(2'b10, 2'd2, 8'h92);
            expect_rsp("ctrl_wr", 8'h00, 1'b0);
            expect_clean("ctrl_wr", 1);
            expect_cyc("ctrl_wr_c0", 0, 3'd0, 1'b0, 8'h92);

            // FIFO read: three not-ready polls, then ready
            start_test(8'h40, 8'h40, 8'h40, 8'hC0, 4, 8'h5A);
            send(2'b00, 2'd0, 8'h00);
            expect_rsp("fifo_rd", 8'h5A, 1'b0);
            expect_clean("fifo_rd", 5);
            for (int i = 0; i < 4; i++) expect_cyc("fifo_rd_poll", i, 3'd0, 1'b1,
                                                   (i == 3) ? 8'hC0 : 8'h40);
            expect_cyc("fifo_rd_data", 4, 3'd1, 1'b1, 8'h5A);

            // FIFO write on register 4
            start_test(8'h40, 8'h00, 8'h00, 8'h00, 1, 8'h00);
            send(2'b01, 2'd3, 8'hA5);
            expect_rsp("fifo_wr", 8'h00, 1'b0);
            expect_clean("fifo_wr", 2);
            expect_cyc("fifo_wr_poll", 0, 3'd6, 1'b1, 8'h40);
            expect_cyc("fifo_wr_data", 1, 3'd7, 1'b0, 8'hA5);

            // Poll timeout at POLL_LIMIT=4
            start_test(8'h3F, 8'h00, 8'h00, 8'h00, 1, 8'hEE);
            send(2'b00, 2'd0, 8'h00);
            expect_rsp("timeout", 8'h3F, 1'b1);
            expect_clean("timeout", 4);
            for (int i = 0; i < 4; i++) expect_cyc("timeout_poll", i, 3'd0, 1'b1, 8'h3F);

            // Raw status read on register 3
            start_test(8'h77, 8'h00, 8'h00, 8'h00, 1, 8'h00);
            send(2'b11, 2'd2, 8'h00);
            expect_rsp("stat_rd", 8'h77, 1'b0);
            expect_clean("stat_rd", 1);
            expect_cyc("stat_rd_c0", 0, 3'd4, 1'b1, 8'h77);

            // Reset while the DATA write is driving the bus
            start_test(8'h40, 8'h00, 8'h00, 8'h00, 1, 8'h00);
            send(2'b01, 2'd1, 8'h3C);
            n = 0;
            while (!oe_m && n < 500) begin
                @(negedge clk);
                n++;
            end
            check("abort_oe_seen", oe_m, 1'b1);
            rc = rsp_cnt;
            #2 rst = 1'b1;
            #1 check("abort_bus_released", {oe_m, cs_b_m, rsp_valid_m}, {1'b0, 1'b1, 1'b0});
            repeat (2) @(negedge clk);
            rst = 1'b0;
            repeat (30) @(negedge clk);
            check("abort_no_rsp", rsp_cnt, rc);
            start_test(8'h00, 8'h00, 8'h00, 8'h00, 1, 8'h00);
            send(2'b10, 2'd0, 8'h5C);
            expect_rsp("after_abort", 8'h00, 1'b0);
            expect_clean("after_abort", 1);
            expect_cyc("after_abort_c0", 0, 3'd0, 1'b0, 8'h5C);
        end

        // Interrupt synchroniser: two-clock latency, inverted
        @(negedge clk);
        h_irq_b = 1'b0;
        @(posedge clk);
        #1 check("irq_assert_1clk", irq_m, 1'b0);
        @(posedge clk);
        #1 check("irq_assert_2clk", irq_m, 1'b1);
        @(negedge clk);
        h_irq_b = 1'b1;
        @(posedge clk);
        #1 check("irq_release_1clk", irq_m, 1'b1);
        @(posedge clk);
        #1 check("irq_release_2clk", irq_m, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
